// File: rtl/mx_block_serializer.sv
// MX block serializer: takes one whole MX block (shared exponent plus
// BLOCK_SIZE sign/mantissa elements) per input handshake and emits one
// encoded byte per element, ctrl 2'b01 on element 0 and 2'b00 otherwise.
// An ACTIVE slot is being serialised while a one-deep PENDING slot lets
// the next block be staged, so the output runs at one byte per cycle
// across block boundaries.
module mx_block_serializer #(
   parameter int BLOCK_SIZE = 4,
   parameter int ELEM_WIDTH = 6
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [7:0]                       in_exp,
   input  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] in_elems,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [7:0]                       out_data,
   output logic [7:0]                       out_exp,
   output logic                             out_first,
   output logic                             out_last,
   output logic                             busy
);

   localparam int IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int DW    = BLOCK_SIZE * ELEM_WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

   logic                  act_full;
   logic [7:0]            act_exp;
   logic [DW-1:0]         act_elems;
   logic [IDX_W-1:0]      idx;

   logic                  pend_full;
   logic [7:0]            pend_exp;
   logic [DW-1:0]         pend_elems;

   logic                  accept;
   logic                  xfer;
   logic                  blk_done;
   logic                  load_act;
   logic                  load_pend;
   logic [ELEM_WIDTH-1:0] cur_elem;

   // in_ready comes only from registered state so upstream sees no
   // combinational path from out_ready or in_valid.
   assign in_ready  = !pend_full;
   assign accept    = in_valid && in_ready;
   assign xfer      = act_full && out_ready;
   assign blk_done  = xfer && (idx == LAST_IDX);
   // An accept can only happen with PENDING empty, so a finishing block
   // always hands ACTIVE straight to the incoming one.
   assign load_act  = accept && (!act_full || blk_done);
   assign load_pend = accept && !load_act;

   // ACTIVE slot and element index; block completion takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_full  <= 1'b0;
         act_exp   <= '0;
         act_elems <= '0;
         idx       <= '0;
      end else if (blk_done) begin
         idx <= '0;
         if (pend_full) begin
            act_exp   <= pend_exp;
            act_elems <= pend_elems;
         end else if (accept) begin
            act_exp   <= in_exp;
            act_elems <= in_elems;
         end else begin
            act_full <= 1'b0;
         end
      end else if (load_act) begin
         act_full  <= 1'b1;
         act_exp   <= in_exp;
         act_elems <= in_elems;
         idx       <= '0;
      end else if (xfer) begin
         idx <= idx + IDX_W'(1);
      end
   end

   // PENDING slot: filled when ACTIVE is busy, drained into ACTIVE on block done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_full  <= 1'b0;
         pend_exp   <= '0;
         pend_elems <= '0;
      end else if (load_pend) begin
         pend_full  <= 1'b1;
         pend_exp   <= in_exp;
         pend_elems <= in_elems;
      end else if (blk_done && pend_full) begin
         pend_full <= 1'b0;
      end
   end

   // Select the element addressed by idx.
   always_comb begin
      cur_elem = '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         if (idx == IDX_W'(i)) cur_elem = act_elems[i*ELEM_WIDTH +: ELEM_WIDTH];
      end
   end

   // Output encoding; everything reads zero while nothing is being sent.
   always_comb begin
      out_valid = act_full;
      out_data  = '0;
      out_exp   = '0;
      out_first = 1'b0;
      out_last  = 1'b0;
      busy      = act_full || pend_full;
      if (act_full) begin
         out_data  = {(idx == '0) ? 2'b01 : 2'b00, cur_elem};
         out_exp   = act_exp;
         out_first = (idx == '0);
         out_last  = (idx == LAST_IDX);
      end
   end

endmodule

// File: tb/tb_mx_block_serializer.sv
// Bench for mx_block_serializer: a BLOCK_SIZE=4 and a BLOCK_SIZE=1 instance,
// one exercised at a time, each checked every cycle against a queue of
// outstanding blocks plus the byte position within the head block.
module tb_mx_block_serializer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        iv4, or4, ir4, ov4, of4, ol4, bz4;
   logic [7:0]  ie4, od4, oe4;
   logic [23:0] iel4;
   logic        iv1, or1, ir1, ov1, of1, ol1, bz1;
   logic [7:0]  ie1, od1, oe1;
   logic [5:0]  iel1;

   mx_block_serializer #(.BLOCK_SIZE(4), .ELEM_WIDTH(6)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_exp(ie4),
      .in_elems(iel4), .out_valid(ov4), .out_ready(or4), .out_data(od4),
      .out_exp(oe4), .out_first(of4), .out_last(ol4), .busy(bz4));

   mx_block_serializer #(.BLOCK_SIZE(1), .ELEM_WIDTH(6)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_exp(ie1),
      .in_elems(iel1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
      .out_exp(oe1), .out_first(of1), .out_last(ol1), .busy(bz1));

   logic       sel;
   logic       o_valid, o_ready_in, o_first, o_last, o_busy;
   logic [7:0] o_data, o_exp;
   assign o_valid    = sel ? ov1 : ov4;
   assign o_ready_in = sel ? ir1 : ir4;
   assign o_first    = sel ? of1 : of4;
   assign o_last     = sel ? ol1 : ol4;
   assign o_busy     = sel ? bz1 : bz4;
   assign o_data     = sel ? od1 : od4;
   assign o_exp      = sel ? oe1 : oe4;

   typedef struct {
      logic [7:0]  e;
      logic [23:0] el;
   } blk_t;

   blk_t       q[$];
   int         pos;
   int         bs;
   logic [7:0] xlog[$];
   int         total = 0;
   int         bad   = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string ctx);
      logic [7:0] e_data, e_exp;
      logic       e_v, e_f, e_l;
      e_v = (q.size() > 0);
      e_data = 8'h00; e_exp = 8'h00; e_f = 1'b0; e_l = 1'b0;
      if (e_v) begin
         e_exp  = q[0].e;
         e_data = {(pos == 0) ? 2'b01 : 2'b00, q[0].el[pos*6 +: 6]};
         e_f    = (pos == 0);
         e_l    = (pos == bs - 1);
      end
      chk({ctx, ".out_valid"}, {7'b0, o_valid},    {7'b0, e_v});
      chk({ctx, ".out_data"},  o_data,             e_data);
      chk({ctx, ".out_exp"},   o_exp,              e_exp);
      chk({ctx, ".out_first"}, {7'b0, o_first},    {7'b0, e_f});
      chk({ctx, ".out_last"},  {7'b0, o_last},     {7'b0, e_l});
      chk({ctx, ".in_ready"},  {7'b0, o_ready_in}, {7'b0, q.size() < 2});
      chk({ctx, ".busy"},      {7'b0, o_busy},     {7'b0, q.size() > 0});
   endtask

   // Called just after a falling edge; returns whether the block was taken.
   task automatic step(input logic v, input logic [7:0] e, input logic [23:0] el,
                       input logic rdy, output logic acc);
      logic hs;
      blk_t b;
      if (sel) begin
         iv1 = v; ie1 = e; iel1 = el[5:0]; or1 = rdy;
         iv4 = 1'b0; ie4 = '0; iel4 = '0; or4 = 1'b0;
      end else begin
         iv4 = v; ie4 = e; iel4 = el; or4 = rdy;
         iv1 = 1'b0; ie1 = '0; iel1 = '0; or1 = 1'b0;
      end
      #1;
      check_outputs(sel ? "bs1" : "bs4");
      acc = v && (q.size() < 2);
      hs  = rdy && (q.size() > 0);
      if (o_valid && rdy) xlog.push_back(o_data);
      @(posedge clk);
      if (hs) begin
         pos++;
         if (pos == bs) begin
            void'(q.pop_front());
            pos = 0;
         end
      end
      if (acc) begin
         b.e  = e;
         b.el = (bs == 1) ? (el & 24'h3F) : el;
         q.push_back(b);
      end
      @(negedge clk);
   endtask

   task automatic offer(input logic [7:0] e, input logic [23:0] el, input logic rdy);
      logic acc;
      int   n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 40) begin
         step(1'b1, e, el, rdy, acc);
         n++;
      end
      if (!acc) begin
         total++; bad++;
         $error("FAIL offer_timeout: observed=not_accepted expected=accepted");
      end
   endtask

   task automatic drain();
      logic acc;
      int   n;
      n = 0;
      while (q.size() > 0 && n < 100) begin
         step(1'b0, 8'h00, 24'h0, 1'b1, acc);
         n++;
      end
      step(1'b0, 8'h00, 24'h0, 1'b1, acc);
      if (q.size() > 0) begin
         total++; bad++;
         $error("FAIL drain_timeout: observed=%0d expected=0", q.size());
      end
   endtask

   task automatic random_run(input int cycles, input logic always_ready);
      logic        hv, acc, rdy;
      logic [7:0]  he;
      logic [23:0] hel;
      hv = 1'b0; he = '0; hel = '0;
      for (int c = 0; c < cycles; c++) begin
         if (!hv && ($urandom_range(0, 2) != 0)) begin
            hv  = 1'b1;
            he  = 8'($urandom);
            hel = 24'($urandom);
         end
         rdy = always_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
         step(hv, he, hel, rdy, acc);
         if (acc) hv = 1'b0;
      end
      drain();
   endtask

   task automatic check_log(input string tag, input logic [7:0] expv[]);
      chk({tag, ".count"}, 8'(xlog.size()), 8'(expv.size()));
      for (int i = 0; i < expv.size() && i < xlog.size(); i++)
         chk($sformatf("%s.byte%0d", tag, i), xlog[i], expv[i]);
   endtask

   initial begin
      logic        acc;
      logic [15:0] pat;
      logic [7:0]  t1[];
      logic [7:0]  t6[];

      sel = 1'b0; bs = 4; pos = 0;
      iv4 = 0; ie4 = '0; iel4 = '0; or4 = 0;
      iv1 = 0; ie1 = '0; iel1 = '0; or1 = 0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_outputs("reset4");
      sel = 1'b1; bs = 1; #1;
      check_outputs("reset1");
      sel = 1'b0; bs = 4;
      rst = 1'b0;
      @(negedge clk);

      // Single block, full-rate drain.
      xlog.delete();
      offer(8'h7F, {6'h00, 6'h3F, 6'h02, 6'h21}, 1'b1);
      drain();
      t1 = '{8'h61, 8'h02, 8'h3F, 8'h00};
      check_log("t1", t1);

      // Three blocks offered back to back at full rate.
      offer(8'h10, 24'($urandom), 1'b1);
      offer(8'h20, 24'($urandom), 1'b1);
      offer(8'h30, 24'($urandom), 1'b1);
      drain();

      // Backpressure pattern across one block.
      xlog.delete();
      pat = 16'b1010_1101_0010_1001;
      offer(8'h55, {6'h11, 6'h22, 6'h33, 6'h04}, pat[0]);
      for (int k = 1; k < 16; k++) step(1'b0, 8'h00, 24'h0, pat[k], acc);
      drain();
      check_log("t3", '{8'h44, 8'h33, 8'h22, 8'h11});

      // Accept coinciding with the last byte, PENDING empty.
      offer(8'hA1, {6'h01, 6'h02, 6'h03, 6'h04}, 1'b1);
      step(1'b0, 8'h00, 24'h0, 1'b1, acc);
      step(1'b0, 8'h00, 24'h0, 1'b1, acc);
      step(1'b1, 8'hB2, {6'h2A, 6'h15, 6'h0F, 6'h30}, 1'b1, acc);
      chk("t4.accept", {7'b0, acc}, 8'h01);
      step(1'b0, 8'h00, 24'h0, 1'b1, acc);
      drain();

      // Asynchronous reset with a block mid-flight and PENDING full.
      offer(8'hC0, 24'($urandom), 1'b1);
      step(1'b1, 8'hC1, 24'($urandom), 1'b1, acc);
      step(1'b0, 8'h00, 24'h0, 1'b1, acc);
      chk("t5.pending_full", {7'b0, o_ready_in}, 8'h00);
      #2 rst = 1'b1;
      #1;
      q.delete(); pos = 0;
      check_outputs("t5.rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      xlog.delete();
      offer(8'hD0, {6'h0D, 6'h0C, 6'h0B, 6'h0A}, 1'b1);
      drain();
      check_log("t5.after", '{8'h4A, 8'h0B, 8'h0C, 8'h0D});

      random_run(400, 1'b0);
      random_run(150, 1'b1);

      // BLOCK_SIZE=1 instance.
      sel = 1'b1; bs = 1; pos = 0;
      @(negedge clk);
      xlog.delete();
      offer(8'h01, 24'h05, 1'b1);
      offer(8'h02, 24'h2A, 1'b1);
      offer(8'h03, 24'h3F, 1'b1);
      drain();
      t6 = '{8'h45, 8'h6A, 8'h7F};
      check_log("t6", t6);
      random_run(300, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mx_block_serializer.md
Name: mx_block_serializer

Overview:
- Transmit-side framer for the MX element byte stream.
- Accepts one whole MX block per handshake: a shared 8-bit exponent plus BLOCK_SIZE sign/mantissa elements.
- Emits one 8-bit encoded byte per element: control bits [7:6] = 2'b01 on the first element of a block, 2'b00 otherwise; element data in [5:0].
- Sits between the host-side block loader and the array input link that feeds the systolic array's element decoders.

Parameters:
- BLOCK_SIZE, 4, elements per MX block (>=1).
- ELEM_WIDTH, 6, bits per element ({sign, mantissa}); fixed at 6 so byte = 2 ctrl + 6 data.
- IDX_W, $clog2(BLOCK_SIZE) (min 1), width of element index counter (derived, not overridden).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  block presented on in_exp/in_elems.
- in_ready  output  1  block slot available.
- in_exp  input  8  shared block exponent.
- in_elems  input  BLOCK_SIZE*ELEM_WIDTH  elements; element 0 in bits [ELEM_WIDTH-1:0].
- out_valid  output  1  out_data holds a valid encoded byte.
- out_ready  input  1  downstream accepts byte.
- out_data  output  8  {ctrl[1:0], elem[5:0]}.
- out_exp  output  8  exponent of block currently being sent.
- out_first  output  1  current byte is element 0 (ctrl == 2'b01).
- out_last  output  1  current byte is element BLOCK_SIZE-1.
- busy  output  1  active or pending slot occupied.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Storage: two block slots.
  - ACTIVE: being serialised, with index idx.
  - PENDING: one-deep queue.
  - Each slot holds an exponent, the elements and a full flag.
- Reset: both slots empty, idx=0.
  - Outputs: out_valid=0, in_ready=1, busy=0, out_data=0, out_exp=0, out_first=0, out_last=0.
- in_ready = !pending_full.
  - Registered-state only; no combinational path from out_ready or in_valid.
- Accept = in_valid && in_ready. Destination:
  - ACTIVE empty, or ACTIVE finishing this cycle with PENDING empty -> load ACTIVE, idx=0.
  - Otherwise -> load PENDING.
- Out handshake = out_valid && out_ready.
- out_valid = active_full.
- out_data = {idx==0 ? 2'b01 : 2'b00, elem[idx]}.
- out_first = out_valid && idx==0; out_last = out_valid && idx==BLOCK_SIZE-1.
- out_exp = active exponent; out_data/out_exp/out_first/out_last = 0 when !out_valid.
- Stall: while out_valid && !out_ready, all outputs and idx hold stable.
- On a handshake with idx < BLOCK_SIZE-1: idx++.
- On a handshake with idx == BLOCK_SIZE-1 (block done):
  - PENDING full -> move PENDING to ACTIVE, idx=0, PENDING empties.
  - Else simultaneous accept -> incoming to ACTIVE, idx=0.
  - Else ACTIVE empties, idx=0.
- Latency: accept in cycle N -> first byte valid in cycle N+1 (ACTIVE was empty).
- Throughput: 1 byte/cycle with out_ready held high, including across block boundaries.
  - No bubble if the next block was accepted by the last-byte cycle.
- BLOCK_SIZE=1: every byte has out_first=out_last=1, ctrl=01.
- busy = active_full || pending_full.
- Reset mid-block: in-flight and pending blocks discarded, outputs to reset values immediately (asynchronous).
- Upstream must hold in_valid/in_exp/in_elems stable until accepted. Block contents are captured at accept, so later input changes do not affect sent bytes.

Test Plan:
1. Single block, BLOCK_SIZE=4, in_exp=8'h7F, elems e0..e3 = 6'h21, 6'h02, 6'h3F, 6'h00, out_ready=1 -> out_data 8'h61, 8'h02, 8'h3F, 8'h00 on four consecutive cycles starting one cycle after accept; out_exp=8'h7F throughout; out_first on byte 0 only, out_last on byte 3 only; then out_valid=0, busy=0.
2. Back-to-back blocks A (exp 8'h10), B (exp 8'h20), C (exp 8'h30) offered continuously, out_ready=1 -> 12 consecutive valid bytes with no gap; in_ready drops to 0 while PENDING is full; out_exp switches 10->20->30 exactly on the out_first bytes.
3. Backpressure: out_ready toggles 1,0,0,1,0,1... during a block -> each byte transferred exactly once, in order; outputs stable across stall cycles; idx never skips.
4. Simultaneous last-byte handshake and accept with PENDING empty -> next cycle shows the new block's element 0 with ctrl 01; PENDING stays empty.
5. Assert rst asynchronously mid-block (after byte 1 of 4, PENDING full) -> same cycle out_valid=0, busy=0, in_ready=1; after release, a new block serialises from element 0 with no stale bytes.
6. BLOCK_SIZE=1 instance, three blocks elems 6'h05, 6'h2A, 6'h3F -> out_data 8'h45, 8'h6A, 8'h7F; out_first=out_last=1 on every byte.
